// File: rtl/buf_sched_pkg.sv
// Shared types and default parameter values for the sample-buffer playback scheduler.
package buf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PLAY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned DEF_DEPTH        = 1024;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_ADDR_DIV     = 16;
  localparam int unsigned DEF_FRAME_CYCLES = 384000;
  localparam int unsigned DEF_MARK_EVERY   = 50;
  localparam int unsigned DEF_MARK_VALUE   = 'hFFFF;
  localparam int unsigned FRAME_W          = 32;

endpackage

// File: rtl/frame_tick_gen.sv
// Playback timebase: a word prescaler producing tick and a frame counter producing frame_end.
// Both counters sit at zero whenever playback is not running.
module frame_tick_gen
  import buf_sched_pkg::*;
#(
  parameter int unsigned ADDR_DIV     = DEF_ADDR_DIV,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic frame_end
);

  localparam int unsigned PRE_W = (ADDR_DIV > 1) ? $clog2(ADDR_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(ADDR_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);

  logic [PRE_W-1:0]   prescaler;
  logic [FRAME_W-1:0] frame_cnt;

  assign tick      = run && (prescaler == PRE_LAST);
  assign frame_end = run && (frame_cnt == FRAME_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      frame_cnt <= '0;
    end else if (!run || frame_end) begin
      // A frame boundary realigns the word grid as well as the frame count.
      prescaler <= '0;
      frame_cnt <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

endmodule

// File: rtl/buffer_play_scheduler.sv
// Shares one single-port sample buffer between a host loader and a real-time playback engine:
// fill once, then play one word per ADDR_DIV cycles with loader refreshes in non-tick slots.
module buffer_play_scheduler
  import buf_sched_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_DIV     = DEF_ADDR_DIV,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned MARK_EVERY   = DEF_MARK_EVERY,
  parameter logic [DATA_W-1:0] MARK_VALUE = DATA_W'(DEF_MARK_VALUE),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              buf_en,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              smp_valid,
  output logic [DATA_W-1:0] smp_data,
  output logic              frame_pulse,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam int unsigned       MARK_DIV  = (MARK_EVERY == 0) ? 1 : MARK_EVERY;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] read_addr;
  logic              read_now;
  logic              is_mark;
  logic              rd_pending;
  logic              rd_mark;
  logic              tick;
  logic              frame_end;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  frame_tick_gen #(
    .ADDR_DIV     (ADDR_DIV),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (state == PLAY),
    .tick      (tick),
    .frame_end (frame_end)
  );

  // A frame boundary restarts playback at word 0, even when it lands on a tick.
  assign read_addr = frame_end ? '0 : rd_ptr;
  assign is_mark   = (MARK_EVERY != 0) && ((32'(read_addr) % MARK_DIV) == 0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    wr_gnt     = 1'b0;
    read_now   = 1'b0;
    buf_en     = 1'b0;
    buf_we     = 1'b0;
    buf_addr   = '0;
    buf_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (cfg_start) state_next = FILL;
      end
      FILL: begin
        if (wr_req) begin
          wr_gnt    = 1'b1;
          buf_en    = 1'b1;
          buf_we    = 1'b1;
          buf_addr  = wr_ptr;
          buf_wdata = wr_data;
        end
        if (cfg_stop)                         state_next = IDLE;
        else if (wr_req && wr_ptr == ADDR_LAST) state_next = PLAY;
      end
      PLAY: begin
        // Playback reads own the port on tick cycles; the loader only stalls there.
        if (tick) begin
          read_now = 1'b1;
          buf_en   = 1'b1;
          buf_addr = read_addr;
        end else if (wr_req) begin
          wr_gnt    = 1'b1;
          buf_en    = 1'b1;
          buf_we    = 1'b1;
          buf_addr  = wr_ptr;
          buf_wdata = wr_data;
        end
        if (cfg_stop) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state == IDLE && cfg_start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (wr_gnt)         wr_ptr <= addr_inc(wr_ptr);
      if (read_now)       rd_ptr <= addr_inc(read_addr);
      else if (frame_end) rd_ptr <= '0;
    end
  end

  // The buffer returns data one cycle after the read; carry the marker decision alongside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending <= 1'b0;
      rd_mark    <= 1'b0;
    end else begin
      rd_pending <= read_now;
      rd_mark    <= read_now && is_mark;
    end
  end

  assign smp_valid   = rd_pending;
  assign smp_data    = !rd_pending ? '0 : (rd_mark ? MARK_VALUE : buf_rdata);
  assign frame_pulse = frame_end;
  assign busy        = (state != IDLE);

endmodule
